// File: rtl/bubble_pkg.sv
// Shared constants and FSM encoding for the bubble-field controller.
// Playfield limits are inclusive pixel coordinates of the 160x120 VGA field.
package bubble_pkg;
  localparam int N_BUB     = 7;
  localparam int X_W       = 8;
  localparam int Y_W       = 7;
  localparam int X_MAX     = 159;
  localparam int Y_TOP     = 0;
  localparam int Y_BOT     = 119;
  localparam int FAST_STEP = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_SPAWN,
    ST_SHOW,
    ST_WAIT,
    ST_ERASE,
    ST_HOLD,
    ST_STEP
  } state_t;
endpackage

// File: rtl/bubble_field_ctrl_if.sv
// Draw handshake plus the published bubble coordinates and the swimmer collision inputs.
interface bubble_field_ctrl_if;
  import bubble_pkg::*;

  logic                   plot_req;
  logic                   plot_ack;
  logic                   erase;
  logic [N_BUB-1:0]       collide;
  logic                   ubound;
  logic [N_BUB*X_W-1:0]   bub_x;
  logic [N_BUB*Y_W-1:0]   bub_y;
  logic [N_BUB-1:0]       bub_valid;

  modport master (
    output plot_req, erase, bub_x, bub_y, bub_valid,
    input  plot_ack, collide, ubound
  );

  modport slave (
    input  plot_req, erase, bub_x, bub_y, bub_valid,
    output plot_ack, collide, ubound
  );
endinterface

// File: rtl/bubble_lfsr.sv
// Fibonacci LFSR (taps on the two top bits) with seed load and zero-seed guard.
module bubble_lfsr #(
  parameter int W      = 15,
  parameter int SEED_W = 10
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load,
  input  logic [SEED_W-1:0] seed,
  output logic [W-1:0]      value
);
  logic [W-1:0] value_reg;
  logic [W-1:0] value_next;

  always_comb begin
    value_next = {value_reg[W-2:0], value_reg[W-1] ^ value_reg[W-2]};
    if (load) begin
      // An all-zero state would lock the register forever.
      value_next = (seed == '0) ? W'(1) : W'(seed);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      value_reg <= W'(1);
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;
endmodule

// File: rtl/bubble_field_ctrl.sv
// Bubble-field controller: spawns, moves and respawns N_BUB bubbles and sequences
// draw/erase requests to the VGA path, publishing coordinates once per frame.
module bubble_field_ctrl
  import bubble_pkg::*;
#(
  parameter int               LFSR_W    = 15,
  parameter int               LIFE      = 20,
  parameter logic [N_BUB-1:0] RISE_MASK = 7'b1111100
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [9:0]                 seed,
  input  logic                       seed_load,
  input  logic                       frame_tick,
  input  logic                       step_tick,
  bubble_field_ctrl_if.master        bus,
  output logic [4:0]                 life_cnt
);
  typedef logic [Y_W:0] yext_t;

  state_t            state_reg;
  state_t            state_next;
  logic [4:0]        life_reg;
  logic [4:0]        life_next;
  logic [LFSR_W-1:0] lfsr_value;
  logic              seed_now;
  logic              publish;

  assign seed_now = (state_reg == ST_SEED);

  bubble_lfsr #(
    .W      (LFSR_W),
    .SEED_W (10)
  ) u_lfsr (
    .clock  (clock),
    .resetn (resetn),
    .load   (seed_now),
    .seed   (seed),
    .value  (lfsr_value)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      life_reg  <= '0;
    end else begin
      state_reg <= state_next;
      life_reg  <= life_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    life_next    = life_reg;
    bus.plot_req = 1'b0;
    bus.erase    = 1'b0;
    case (state_reg)
      ST_IDLE:  state_next = ST_SEED;
      ST_SEED:  state_next = ST_SPAWN;
      ST_SPAWN: begin
        life_next  = '0;
        state_next = ST_SHOW;
      end
      ST_SHOW: begin
        bus.plot_req = 1'b1;
        if (bus.plot_ack) state_next = ST_WAIT;
      end
      ST_WAIT:  if (frame_tick) state_next = ST_ERASE;
      ST_ERASE: begin
        bus.plot_req = 1'b1;
        bus.erase    = 1'b1;
        if (bus.plot_ack) state_next = ST_HOLD;
      end
      ST_HOLD:  if (step_tick) state_next = ST_STEP;
      ST_STEP: begin
        life_next  = life_reg + 5'd1;
        state_next = (life_next == 5'(LIFE)) ? ST_SPAWN : ST_SHOW;
      end
      default:  state_next = ST_IDLE;
    endcase
    // A reseed abandons whatever handshake is open.
    if (seed_load && state_reg != ST_IDLE) state_next = ST_SEED;
  end

  assign publish  = (state_next == ST_SHOW) && (state_reg != ST_SHOW);
  assign life_cnt = life_reg;

  for (genvar gi = 0; gi < N_BUB; gi++) begin : g_chan
    localparam int ROT = (3 * gi) % LFSR_W;

    logic [LFSR_W-1:0] rot;
    logic [X_W-1:0]    raw_x;
    logic [X_W-1:0]    cand_x;
    logic [Y_W-1:0]    raw_y;
    logic [Y_W-1:0]    cand_y;
    yext_t             y_ext;
    yext_t             y_mov;
    logic              out_of_range;
    logic [X_W-1:0]    wx_reg, wx_next, px_reg;
    logic [Y_W-1:0]    wy_reg, wy_next, py_reg;
    logic              wv_reg, wv_next, pv_reg;

    // Per-channel rotation decorrelates the channels drawn from one LFSR.
    assign rot    = (lfsr_value << ROT) | (lfsr_value >> ((LFSR_W - ROT) % LFSR_W));
    assign raw_x  = rot[LFSR_W-1 -: X_W];
    assign raw_y  = rot[Y_W-1:0];
    assign cand_x = (raw_x > X_W'(X_MAX)) ? raw_x - X_W'(X_MAX + 1) : raw_x;
    assign cand_y = (raw_y > Y_W'(Y_BOT)) ? raw_y - Y_W'(Y_BOT + 1) : raw_y;
    assign y_ext  = {1'b0, wy_reg};

    always_comb begin
      y_mov = y_ext;
      if (!RISE_MASK[gi]) begin
        y_mov = y_ext + (bus.collide[gi] ? yext_t'(FAST_STEP) : yext_t'(1));
      end else if (bus.collide[gi] && !bus.ubound) begin
        y_mov = y_ext - yext_t'(FAST_STEP);
      end else if (bus.collide[gi]) begin
        y_mov = y_ext;
      end else if (bus.ubound) begin
        y_mov = y_ext + yext_t'(1);
      end else begin
        y_mov = y_ext - yext_t'(1);
      end
    end

    // The extra MSB catches rising past the top row (Y_TOP is row 0).
    assign out_of_range = y_mov[Y_W] || (y_mov > yext_t'(Y_BOT));

    always_comb begin
      wx_next = wx_reg;
      wy_next = wy_reg;
      wv_next = wv_reg;
      if (state_reg == ST_SPAWN) begin
        wx_next = cand_x;
        wy_next = cand_y;
        wv_next = 1'b1;
      end else if (state_reg == ST_STEP && wv_reg) begin
        if (out_of_range) begin
          wx_next = cand_x;
          wy_next = cand_y;
        end else begin
          wy_next = y_mov[Y_W-1:0];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (!resetn) begin
        wx_reg <= '0;
        wy_reg <= '0;
        wv_reg <= 1'b0;
        px_reg <= '0;
        py_reg <= '0;
        pv_reg <= 1'b0;
      end else begin
        wx_reg <= wx_next;
        wy_reg <= wy_next;
        wv_reg <= wv_next;
        if (publish) begin
          px_reg <= wx_next;
          py_reg <= wy_next;
          pv_reg <= wv_next;
        end
      end
    end

    assign bus.bub_x[gi*X_W +: X_W] = px_reg;
    assign bus.bub_y[gi*Y_W +: Y_W] = py_reg;
    assign bus.bub_valid[gi]        = pv_reg;
  end
endmodule

// File: tb/tb_bubble_field_ctrl.sv
// Directed/randomised bench for bubble_field_ctrl, checked every cycle against a
// behavioural model built from the field rules with plain integer arithmetic.
module tb_bubble_field_ctrl;
  import bubble_pkg::*;

  localparam int               LFSR_W = 15;
  localparam int               LIFE   = 20;
  localparam logic [N_BUB-1:0] RISE   = 7'b1111100;

  localparam int P_IDLE = 0, P_SEED = 1, P_SPAWN = 2, P_SHOW = 3;
  localparam int P_WAIT = 4, P_ERASE = 5, P_HOLD = 6, P_STEP = 7;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] seed = '0;
  logic       seed_load = 1'b0;
  logic       frame_tick = 1'b0;
  logic       step_tick = 1'b0;
  logic [4:0] life_cnt;

  bubble_field_ctrl_if bus();

  bubble_field_ctrl #(
    .LFSR_W    (LFSR_W),
    .LIFE      (LIFE),
    .RISE_MASK (RISE)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .seed       (seed),
    .seed_load  (seed_load),
    .frame_tick (frame_tick),
    .step_tick  (step_tick),
    .bus        (bus),
    .life_cnt   (life_cnt)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  int m_ph, m_lfsr, m_life, m_step_lfsr;
  int m_x [N_BUB];
  int m_y [N_BUB];
  bit m_v [N_BUB];
  int m_px [N_BUB];
  int m_py [N_BUB];
  bit m_pv [N_BUB];

  function automatic int rot_of(int l, int k);
    int r = (3 * k) % LFSR_W;
    return ((l << r) | (l >> (LFSR_W - r))) & ((1 << LFSR_W) - 1);
  endfunction

  function automatic int cand_x(int l, int k);
    int v = (rot_of(l, k) >> (LFSR_W - X_W)) & ((1 << X_W) - 1);
    return (v > X_MAX) ? v - (X_MAX + 1) : v;
  endfunction

  function automatic int cand_y(int l, int k);
    int v = rot_of(l, k) & ((1 << Y_W) - 1);
    return (v > Y_BOT) ? v - (Y_BOT + 1) : v;
  endfunction

  task automatic model_clock();
    int nph, nl, r;
    if (!resetn) begin
      m_ph = P_IDLE; m_lfsr = 1; m_life = 0; m_step_lfsr = 0;
      for (int k = 0; k < N_BUB; k++) begin
        m_x[k] = 0; m_y[k] = 0; m_v[k] = 0; m_px[k] = 0; m_py[k] = 0; m_pv[k] = 0;
      end
      return;
    end
    if (m_ph == P_SEED) nl = (seed == 0) ? 1 : int'(seed);
    else nl = ((m_lfsr << 1) & ((1 << LFSR_W) - 1)) | (((m_lfsr >> (LFSR_W - 1)) ^ (m_lfsr >> (LFSR_W - 2))) & 1);
    nph = m_ph;
    case (m_ph)
      P_IDLE:  nph = P_SEED;
      P_SEED:  nph = P_SPAWN;
      P_SPAWN: begin
        for (int k = 0; k < N_BUB; k++) begin
          m_x[k] = cand_x(m_lfsr, k); m_y[k] = cand_y(m_lfsr, k); m_v[k] = 1;
        end
        m_life = 0;
        nph = P_SHOW;
      end
      P_SHOW:  if (bus.plot_ack) nph = P_WAIT;
      P_WAIT:  if (frame_tick) nph = P_ERASE;
      P_ERASE: if (bus.plot_ack) nph = P_HOLD;
      P_HOLD:  if (step_tick) nph = P_STEP;
      default: begin
        m_step_lfsr = m_lfsr;
        for (int k = 0; k < N_BUB; k++) begin
          if (m_v[k]) begin
            if (!RISE[k]) r = m_y[k] + (bus.collide[k] ? FAST_STEP : 1);
            else if (bus.collide[k] && !bus.ubound) r = m_y[k] - FAST_STEP;
            else if (bus.collide[k]) r = m_y[k];
            else if (bus.ubound) r = m_y[k] + 1;
            else r = m_y[k] - 1;
            if (r > Y_BOT || r < Y_TOP) begin
              m_x[k] = cand_x(m_lfsr, k); m_y[k] = cand_y(m_lfsr, k);
            end else begin
              m_y[k] = r;
            end
          end
        end
        m_life = m_life + 1;
        nph = (m_life == LIFE) ? P_SPAWN : P_SHOW;
      end
    endcase
    if (seed_load && m_ph != P_IDLE) nph = P_SEED;
    if (nph == P_SHOW && m_ph != P_SHOW) begin
      for (int k = 0; k < N_BUB; k++) begin
        m_px[k] = m_x[k]; m_py[k] = m_y[k]; m_pv[k] = m_v[k];
      end
    end
    m_ph = nph;
    m_lfsr = nl;
  endtask

  function automatic logic [63:0] pack_x();
    logic [63:0] v = '0;
    for (int k = 0; k < N_BUB; k++) v[k*X_W +: X_W] = X_W'(m_px[k]);
    return v;
  endfunction

  function automatic logic [63:0] pack_y();
    logic [63:0] v = '0;
    for (int k = 0; k < N_BUB; k++) v[k*Y_W +: Y_W] = Y_W'(m_py[k]);
    return v;
  endfunction

  function automatic logic [63:0] pack_v();
    logic [63:0] v = '0;
    for (int k = 0; k < N_BUB; k++) v[k] = m_pv[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bub_x", 64'(bus.bub_x), pack_x());
    chk("bub_y", 64'(bus.bub_y), pack_y());
    chk("bub_valid", 64'(bus.bub_valid), pack_v());
    chk("plot_req", 64'(bus.plot_req), 64'(m_ph == P_SHOW || m_ph == P_ERASE));
    chk("erase", 64'(bus.erase), 64'(m_ph == P_ERASE));
    chk("life_cnt", 64'(life_cnt), 64'(m_life));
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clock);
    #1;
    seed_load = 1'b0; frame_tick = 1'b0; step_tick = 1'b0; bus.plot_ack = 1'b0;
    $display("cycle t=%0t phase=%0d req=%0b erase=%0b life=%0d", $time, m_ph, bus.plot_req, bus.erase, life_cnt);
    check_all();
  endtask

  // One draw/erase/step round starting from SHOW, with optional stray pulses.
  task automatic frame(input logic [N_BUB-1:0] col, input logic ub, input int d_show,
                       input bit both, input int d_wait);
    for (int i = 0; i < d_show; i++) begin
      step_tick = 1'($urandom_range(0, 1)); frame_tick = 1'($urandom_range(0, 1)); cyc();
    end
    bus.plot_ack = 1'b1; frame_tick = both; cyc();
    for (int i = 0; i < d_wait; i++) begin
      bus.plot_ack = 1'($urandom_range(0, 1)); step_tick = 1'($urandom_range(0, 1)); cyc();
    end
    frame_tick = 1'b1; cyc();
    bus.plot_ack = 1'b1; cyc();
    bus.collide = col; bus.ubound = ub; step_tick = 1'b1; cyc();
    cyc();
    if (m_ph == P_SPAWN) cyc();
  endtask

  task automatic restart(input logic [9:0] s);
    seed = s; seed_load = 1'b1; cyc(); cyc(); cyc();
  endtask

  initial begin
    logic [63:0] hold_x, hold_y;
    int y0, y1, y2, lf;
    bit hit;
    bus.plot_ack = 1'b0; bus.collide = '0; bus.ubound = 1'b0;

    // Reset and bring-up
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_req", 64'(bus.plot_req), 64'd0);
    chk("rst_valid", 64'(bus.bub_valid), 64'd0);
    resetn = 1'b1; seed = 10'h2A5;
    cyc(); cyc(); cyc();
    seed_load = 1'b1; cyc(); cyc();
    chk("spawn_state", 64'(dut.state_reg), 64'(ST_SPAWN));
    cyc();
    chk("show_req", 64'(bus.plot_req), 64'd1);
    chk("show_erase", 64'(bus.erase), 64'd0);
    chk("all_valid", 64'(bus.bub_valid), 64'h7F);
    for (int k = 0; k < N_BUB; k++)
      chk("range", 64'(bus.bub_x[k*X_W +: X_W] <= X_MAX && bus.bub_y[k*Y_W +: Y_W] <= Y_BOT), 64'd1);

    // plot_ack held off: request and coordinates stay put, stray steps ignored
    hold_x = pack_x(); hold_y = pack_y();
    for (int i = 0; i < 50; i++) begin
      step_tick = 1'($urandom_range(0, 1)); cyc();
    end
    chk("hold_req", 64'(bus.plot_req), 64'd1);
    chk("hold_x", 64'(bus.bub_x), hold_x);
    chk("hold_y", 64'(bus.bub_y), hold_y);
    frame('0, 1'b0, 0, 1'b1, 1);

    // Full-field lifetime
    restart(10'($urandom));
    for (int i = 0; i < LIFE - 1; i++) frame(7'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0, 0);
    chk("life_19", 64'(life_cnt), 64'(LIFE - 1));
    frame(7'($urandom), 1'($urandom_range(0, 1)), 0, 1'b0, 0);
    chk("life_wrap", 64'(life_cnt), 64'd0);

    // Rising channel 2 pinned by collide+ubound, then pushed down by ubound alone
    restart(10'($urandom));
    y2 = m_py[2];
    for (int i = 0; i < 5; i++) begin
      frame(7'b0000100, 1'b1, 0, 1'b0, 0);
      chk("rise_hold", 64'(bus.bub_y[2*Y_W +: Y_W]), 64'(y2));
    end
    for (int i = 0; i < 5; i++) begin
      y2 = m_py[2];
      frame('0, 1'b1, 0, 1'b0, 0);
      if (y2 < Y_BOT) chk("rise_inc", 64'(bus.bub_y[2*Y_W +: Y_W]), 64'(y2 + 1));
    end

    // Channel 0 falls fast until it leaves the bottom and respawns
    restart(10'($urandom));
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      y0 = m_py[0]; y1 = m_py[1]; lf = m_life;
      frame({5'($urandom), 1'b0, 1'b1}, 1'($urandom_range(0, 1)), 0, 1'b0, 0);
      if (lf < LIFE - 1) begin
        if (y1 < Y_BOT) chk("fall1", 64'(bus.bub_y[Y_W +: Y_W]), 64'(y1 + 1));
        if (y0 + FAST_STEP > Y_BOT) begin
          chk("respawn_y", 64'(bus.bub_y[0 +: Y_W]), 64'(cand_y(m_step_lfsr, 0)));
          chk("respawn_x", 64'(bus.bub_x[0 +: X_W]), 64'(cand_x(m_step_lfsr, 0)));
          chk("respawn_valid", 64'(bus.bub_valid[0]), 64'd1);
          hit = 1'b1;
        end
      end
    end
    chk("respawn_seen", 64'(hit), 64'd1);

    // Randomised rounds including ack+frame_tick collisions
    for (int i = 0; i < 30; i++)
      frame(7'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    // Zero seed guard, then reseed in the middle of an erase
    seed = '0; seed_load = 1'b1; cyc(); cyc();
    chk("lfsr_nz", 64'(dut.lfsr_value), 64'd1);
    cyc();
    bus.plot_ack = 1'b1; cyc();
    frame_tick = 1'b1; cyc();
    chk("erase_on", 64'(bus.erase), 64'd1);
    seed = 10'($urandom); seed_load = 1'b1; cyc();
    chk("abort_req", 64'(bus.plot_req), 64'd0);
    cyc(); cyc();
    chk("restart_req", 64'(bus.plot_req), 64'd1);
    chk("restart_life", 64'(life_cnt), 64'd0);
    frame(7'($urandom), 1'b0, 1, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
